// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared constants, op encoding and modular add/sub/half helpers for the butterfly
package bf_pkg;

  localparam int BF_WIDTH     = 12;
  localparam int BF_Q         = 3329;
  localparam int BF_BARRETT_K = 2 * BF_WIDTH;
  localparam int BF_BARRETT_M = (1 << BF_BARRETT_K) / BF_Q;

  localparam logic BF_NTT  = 1'b0;
  localparam logic BF_INTT = 1'b1;

  // (x + y) mod q for x, y already in [0, q-1]
  function automatic logic [31:0] add_mod(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] q);
    logic [31:0] s;
    s = x + y;
    if (s >= q) s = s - q;
    return s;
  endfunction

  // (x - y) mod q for x, y already in [0, q-1]
  function automatic logic [31:0] sub_mod(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] q);
    logic [31:0] d;
    if (x >= y) d = x - y;
    else        d = x + q - y;
    return d;
  endfunction

  // x * 2^-1 mod q for odd q
  function automatic logic [31:0] half_mod(input logic [31:0] x, input logic [31:0] q);
    logic [31:0] h;
    if (x[0]) h = (x + q) >> 1;
    else      h = x >> 1;
    return h;
  endfunction

endpackage

// File: rtl/bf_mod_mul.sv
// rtl/bf_mod_mul.sv - pipelined Barrett modular multiplier, MUL_LAT register stages, stall via ce
module bf_mod_mul
  import bf_pkg::*;
#(
  parameter int WIDTH   = BF_WIDTH,
  parameter int Q       = BF_Q,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] p
);

  localparam int K = 2 * WIDTH;

  typedef logic [K-1:0] prod_t;
  typedef logic [2*K:0] wide_t;
  typedef logic [K+1:0] dw_t;

  localparam wide_t M_W  = wide_t'((64'd1 << K) / 64'(Q));
  localparam dw_t   Q_DW = dw_t'(Q);

  prod_t            prod_q;
  prod_t            prod_d;
  wide_t            est;
  dw_t              qhat;
  dw_t              r0;
  dw_t              r1;
  dw_t              r2;
  logic [WIDTH-1:0] red;
  logic             unused_bits;

  // First stage captures the raw product so the reduction starts from a register
  always_comb begin
    prod_d = prod_q;
    if (ce) prod_d = prod_t'(x) * prod_t'(y);
  end

  // Product register
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  // Barrett: quotient estimate is at most two short, so two conditional subtracts finish it
  always_comb begin
    est  = wide_t'(prod_q) * M_W;
    qhat = dw_t'(est >> K);
    r0   = dw_t'(prod_q) - qhat * Q_DW;
    r1   = (r0 >= Q_DW) ? r0 - Q_DW : r0;
    r2   = (r1 >= Q_DW) ? r1 - Q_DW : r1;
    red  = r2[WIDTH-1:0];
  end

  assign unused_bits = ^{est[K-1:0], r2[K+1:WIDTH]};

  if (MUL_LAT == 1) begin : g_lat1
    assign p = red;
  end else begin : g_latn
    logic [WIDTH-1:0] dly_q [MUL_LAT-1];
    logic [WIDTH-1:0] dly_d [MUL_LAT-1];

    // Remaining stages carry the reduced product, holding while stalled
    always_comb begin
      dly_d = dly_q;
      if (ce) begin
        dly_d[0] = red;
        for (int i = 1; i < MUL_LAT - 1; i++) dly_d[i] = dly_q[i-1];
      end
    end

    // Delay-line registers
    always_ff @(posedge clk) begin
      dly_q <= dly_d;
    end

    assign p = dly_q[MUL_LAT-2];
  end

endmodule

// File: rtl/bf_pipe_lanes.sv
// rtl/bf_pipe_lanes.sv - multi-lane CT/GS butterfly pipeline, latency MUL_LAT+1; macro INTT_HALVE_EN halves INTT outputs
module bf_pipe_lanes
  import bf_pkg::*;
#(
  parameter int WIDTH   = BF_WIDTH,
  parameter int Q       = BF_Q,
  parameter int LANES   = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0] in_w,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_op,
  output logic [LANES*WIDTH-1:0] out_a,
  output logic [LANES*WIDTH-1:0] out_b,
  output logic                   busy
);

  typedef logic [WIDTH-1:0] coef_t;

  logic                   ce;
  logic [MUL_LAT-1:0]     vld_q;
  logic [MUL_LAT-1:0]     vld_d;
  logic [MUL_LAT-1:0]     op_q;
  logic [MUL_LAT-1:0]     op_d;
  coef_t                  a_pipe_q [MUL_LAT][LANES];
  coef_t                  a_pipe_d [MUL_LAT][LANES];
  coef_t                  a_pre    [LANES];
  coef_t                  mul_x    [LANES];
  coef_t                  mul_p    [LANES];
  coef_t                  res_a    [LANES];
  coef_t                  res_b    [LANES];
  logic                   out_valid_q;
  logic                   out_valid_d;
  logic                   out_op_q;
  logic                   out_op_d;
  logic [LANES*WIDTH-1:0] out_a_q;
  logic [LANES*WIDTH-1:0] out_a_d;
  logic [LANES*WIDTH-1:0] out_b_q;
  logic [LANES*WIDTH-1:0] out_b_d;

  assign ce        = !out_valid_q || out_ready;
  assign in_ready  = ce;
  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign busy      = (|vld_q) || out_valid_q;

  // Stage 0: INTT does its add/sub before the multiplier; NTT feeds b straight in
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (in_op == BF_INTT) begin
        a_pre[l] = coef_t'(add_mod(32'(in_a[l*WIDTH +: WIDTH]), 32'(in_b[l*WIDTH +: WIDTH]), 32'(Q)));
        mul_x[l] = coef_t'(sub_mod(32'(in_a[l*WIDTH +: WIDTH]), 32'(in_b[l*WIDTH +: WIDTH]), 32'(Q)));
      end else begin
        a_pre[l] = in_a[l*WIDTH +: WIDTH];
        mul_x[l] = in_b[l*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bf_mod_mul #(
      .WIDTH   (WIDTH),
      .Q       (Q),
      .MUL_LAT (MUL_LAT)
    ) u_mul (
      .clk (clk),
      .ce  (ce),
      .x   (mul_x[l]),
      .y   (in_w[l*WIDTH +: WIDTH]),
      .p   (mul_p[l])
    );
  end

  // Final stage: NTT add/sub around the product; INTT passes a' and the product through
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (op_q[MUL_LAT-1] == BF_NTT) begin
        res_a[l] = coef_t'(add_mod(32'(a_pipe_q[MUL_LAT-1][l]), 32'(mul_p[l]), 32'(Q)));
        res_b[l] = coef_t'(sub_mod(32'(a_pipe_q[MUL_LAT-1][l]), 32'(mul_p[l]), 32'(Q)));
      end else begin
        res_a[l] = a_pipe_q[MUL_LAT-1][l];
        res_b[l] = mul_p[l];
      end
`ifdef INTT_HALVE_EN
      if (op_q[MUL_LAT-1] == BF_INTT) begin
        res_a[l] = coef_t'(half_mod(32'(res_a[l]), 32'(Q)));
        res_b[l] = coef_t'(half_mod(32'(res_b[l]), 32'(Q)));
      end
`endif
    end
  end

  // Advance every stage together on ce, otherwise hold
  always_comb begin
    vld_d       = vld_q;
    op_d        = op_q;
    a_pipe_d    = a_pipe_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    if (ce) begin
      vld_d[0]    = in_valid;
      op_d[0]     = in_op;
      a_pipe_d[0] = a_pre;
      for (int s = 1; s < MUL_LAT; s++) begin
        vld_d[s]    = vld_q[s-1];
        op_d[s]     = op_q[s-1];
        a_pipe_d[s] = a_pipe_q[s-1];
      end
      out_valid_d = vld_q[MUL_LAT-1];
      out_op_d    = op_q[MUL_LAT-1];
      for (int l = 0; l < LANES; l++) begin
        out_a_d[l*WIDTH +: WIDTH] = res_a[l];
        out_b_d[l*WIDTH +: WIDTH] = res_b[l];
      end
    end
  end

  // Pipeline and output registers; reset drops every in-flight beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q       <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        for (int l = 0; l < LANES; l++) a_pipe_q[s][l] <= '0;
      end
    end else begin
      vld_q       <= vld_d;
      op_q        <= op_d;
      a_pipe_q    <= a_pipe_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

endmodule

// File: tb/tb_bf_pipe_lanes.sv
// tb/tb_bf_pipe_lanes.sv - scoreboard bench for bf_pipe_lanes (expectations follow INTT_HALVE_EN)
module tb_bf_pipe_lanes;

  localparam int W   = 12;
  localparam int L   = 2;
  localparam int ML  = 3;
  localparam int LAT = ML + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           in_op;
  logic [L*W-1:0] in_a;
  logic [L*W-1:0] in_b;
  logic [L*W-1:0] in_w;
  logic           out_valid;
  logic           out_ready;
  logic           out_op;
  logic [L*W-1:0] out_a;
  logic [L*W-1:0] out_b;
  logic           busy;

  always #5 clk = ~clk;

  bf_pipe_lanes #(
    .WIDTH   (W),
    .Q       (3329),
    .LANES   (L),
    .MUL_LAT (ML)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_a     (out_a),
    .out_b     (out_b),
    .busy      (busy)
  );

  typedef struct packed {
    logic           op;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [L*W-1:0] w;
    logic [L*W-1:0] ea;
    logic [L*W-1:0] eb;
  } vec_t;

  typedef struct packed {
    logic           op;
    logic [L*W-1:0] ea;
    logic [L*W-1:0] eb;
    logic           lat;
    logic [31:0]    cyc;
  } exp_t;

  vec_t        vecs [10];
  exp_t        sb [$];
  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // h0/h1 are the INTT results after halving; ignored for NTT rows
  task automatic set_vec(input int i, input logic op,
                         input int a0, input int b0, input int w0, input int ea0, input int eb0,
                         input int ha0, input int hb0,
                         input int a1, input int b1, input int w1, input int ea1, input int eb1,
                         input int ha1, input int hb1);
    vecs[i].op = op;
    vecs[i].a  = {12'(a1), 12'(a0)};
    vecs[i].b  = {12'(b1), 12'(b0)};
    vecs[i].w  = {12'(w1), 12'(w0)};
    vecs[i].ea = {12'(ea1), 12'(ea0)};
    vecs[i].eb = {12'(eb1), 12'(eb0)};
`ifdef INTT_HALVE_EN
    if (op) begin
      vecs[i].ea = {12'(ha1), 12'(ha0)};
      vecs[i].eb = {12'(hb1), 12'(hb0)};
    end
`endif
  endtask

  // Presents one beat, waits (bounded) for acceptance, records the expectation
  task automatic send(input int idx, input bit push, input bit lat);
    int guard = 0;
    in_valid = 1'b1;
    in_op    = vecs[idx].op;
    in_a     = vecs[idx].a;
    in_b     = vecs[idx].b;
    in_w     = vecs[idx].w;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
    else if (push) sb.push_back({vecs[idx].op, vecs[idx].ea, vecs[idx].eb, lat, cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on every transfer, check the held beat during a stall
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got out_a=%0h out_b=%0h, expected no beat", out_a, out_b);
      end else if (out_ready) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_op", 64'(out_op), 64'(e.op));
        chk("out_a", 64'(out_a), 64'(e.ea));
        chk("out_b", 64'(out_b), 64'(e.eb));
        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(LAT));
      end else begin
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        chk("stall_out_a", 64'(out_a), 64'(sb[0].ea));
        chk("stall_out_b", 64'(out_b), 64'(sb[0].eb));
        chk("stall_out_op", 64'(out_op), 64'(sb[0].op));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_w      = '0;
    out_ready = 1'b1;

    set_vec(0, 1'b0, 5, 7, 17, 124, 3215, 0, 0,        3328, 3328, 3328, 0, 3327, 0, 0);
    set_vec(1, 1'b1, 5, 7, 17, 12, 3295, 6, 3312,      3328, 3328, 3328, 3327, 0, 3328, 0);
    set_vec(2, 1'b0, 0, 0, 0, 0, 0, 0, 0,              1, 2, 3, 7, 3324, 0, 0);
    set_vec(3, 1'b1, 0, 0, 0, 0, 0, 0, 0,              1, 2, 3, 3, 3326, 1666, 1663);
    set_vec(4, 1'b0, 100, 200, 300, 178, 22, 0, 0,     3000, 1000, 2000, 2271, 400, 0, 0);
    set_vec(5, 1'b1, 100, 200, 300, 300, 3290, 150, 1645, 3000, 1000, 2000, 671, 1871, 2000, 2600);
    set_vec(6, 1'b0, 3328, 1, 1, 0, 3327, 0, 0,        0, 3328, 3328, 1, 3328, 0, 0);
    set_vec(7, 1'b1, 3328, 1, 1, 0, 3327, 0, 3328,     0, 3328, 3328, 3328, 3328, 1664, 1664);
    set_vec(8, 1'b0, 3328, 3328, 3328, 0, 3327, 0, 0,  5, 7, 17, 124, 3215, 0, 0);
    set_vec(9, 1'b1, 3328, 3328, 3328, 3327, 0, 3328, 0, 5, 7, 17, 12, 3295, 6, 3312);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_op", 64'(out_op), 64'(0));
    chk("rst_out_a", 64'(out_a), 64'(0));
    chk("rst_out_b", 64'(out_b), 64'(0));
    @(posedge clk);
    #1;

    send(0, 1'b1, 1'b1); drain();
    send(1, 1'b1, 1'b1); drain();
    send(8, 1'b1, 1'b1); drain();
    send(9, 1'b1, 1'b1); drain();

    for (int i = 0; i < 8; i++) send(i, 1'b1, 1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) send(7 - i, 1'b1, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    send(2, 1'b0, 1'b0);
    send(3, 1'b0, 1'b0);
    send(4, 1'b0, 1'b0);
    chk("busy_inflight", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_out_a", 64'(out_a), 64'(0));
    chk("mid_rst_out_b", 64'(out_b), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
